// File: rtl/uart_send_fifo.sv
// Byte FIFO between the bus controller's UART send register and the monitor's UART transmitter.
// Optional sticky overflow flag enabled by defining UART_SEND_FIFO_OVERFLOW_EN.
module uart_send_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned BUSY_WAIT  = 3
) (
    input  logic                  MCLK_IN,
    input  logic                  RESET_n_IN,
    input  logic                  PUSH_IN,
    input  logic [7:0]            PUSH_BYTE_IN,
    input  logic                  SEND_BUSY_IN,
    input  logic                  CLEAR_OVERFLOW_IN,
    output logic                  FULL,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  SEND_TRIGGER,
    output logic [7:0]            SEND_BYTE,
    output logic                  OVERFLOW
);

    localparam int unsigned DEPTH   = 32'(1) << DEPTH_LOG2;
    localparam int unsigned LEVEL_W = DEPTH_LOG2 + 1;
    localparam int unsigned CNT_W   = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]      level_q, level_d;
    logic                    full_q, full_d;
    logic                    trig_q, trig_d;
    logic [7:0]              byte_q, byte_d;
    logic                    push_q, push_d;
    logic [7:0]              mem_q [DEPTH];

    logic push_edge_c;
    logic push_ok_c;
    logic pop_c;

    // Full is judged on the pre-pop occupancy, so a push meeting a pop while full is dropped.
    assign push_edge_c = PUSH_IN & ~push_q;
    assign push_ok_c   = push_edge_c & ~full_q;
    assign pop_c       = (state_q == ST_IDLE) && (level_q != '0) && !SEND_BUSY_IN;

    always_comb begin
        push_d   = PUSH_IN;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        byte_d   = byte_q;
        state_d  = state_q;
        cnt_d    = cnt_q;

        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            byte_d   = mem_q[rd_ptr_q];
        end
        case ({push_ok_c, pop_c})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LEVEL_W'(DEPTH));

        // Drain handshake: pop, pulse trigger, wait for busy (or give up), wait for idle.
        case (state_q)
            ST_IDLE: begin
                if (pop_c) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY: begin
                if (SEND_BUSY_IN) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_WAIT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!SEND_BUSY_IN) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        trig_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
        if (!RESET_n_IN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            trig_q   <= 1'b0;
            byte_q   <= 8'h00;
            push_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            trig_q   <= trig_d;
            byte_q   <= byte_d;
            push_q   <= push_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge MCLK_IN) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= PUSH_BYTE_IN;
        end
    end

`ifdef UART_SEND_FIFO_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (CLEAR_OVERFLOW_IN) begin
            overflow_d = 1'b0;
        end
        if (push_edge_c && full_q) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge MCLK_IN or negedge RESET_n_IN) begin
        if (!RESET_n_IN) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign OVERFLOW = overflow_q;
`else
    logic unused_clear;
    assign unused_clear = CLEAR_OVERFLOW_IN;
    assign OVERFLOW     = 1'b0;
`endif

    assign FULL         = full_q;
    assign LEVEL        = level_q;
    assign SEND_TRIGGER = trig_q;
    assign SEND_BYTE    = byte_q;

endmodule
